// File: rtl/bcd4_run_ctrl.sv
// bcd4_run_ctrl: start/stop/clear sequencer for a 4-digit BCD up/down counter.
// A prescaler turns clk into count ticks, and a free-running scan selects one
// digit at a time for a shared 7-segment decoder.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | digits held (normally 0000), prescaler held, waiting for start
// S_RUN   | prescaler advancing; each tick applies one BCD step
// S_PAUSE | digits and partial prescaler period frozen; start resumes
module bcd4_run_ctrl #(
  parameter int unsigned PRESCALE = 50000,
  parameter int unsigned SCAN_DIV = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stop,
  input  logic        clear,
  input  logic        up,
  output logic [15:0] digits,
  output logic        running,
  output logic        wrap,
  output logic [3:0]  an,
  output logic [3:0]  seg_bcd
);

  localparam logic [19:0] PRESC_LAST = 20'(PRESCALE - 1);
  localparam logic [15:0] SCAN_LAST  = 16'(SCAN_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [19:0] presc_q, presc_d;
  logic [15:0] digits_q, digits_d;
  logic        wrap_q, wrap_d;
  logic        running_q, running_d;
  logic [15:0] scan_q, scan_d;
  logic [1:0]  sel_q, sel_d;
  logic        tick;
  logic [15:0] bcd_next;
  logic        bcd_cout;
  logic        bcd_cy;
  logic [3:0]  bcd_dig;

  assign tick = (state_q == S_RUN) && (presc_q == PRESC_LAST);

  // One BCD step across all four decades; carry/borrow ripples from d0 upward.
  always_comb begin
    bcd_next = digits_q;
    bcd_cy   = 1'b1;
    bcd_dig  = 4'd0;
    for (int i = 0; i < 4; i++) begin
      bcd_dig = digits_q[4*i +: 4];
      if (bcd_cy) begin
        if (up) begin
          if (bcd_dig >= 4'd9) begin
            bcd_next[4*i +: 4] = 4'd0;
          end else begin
            bcd_next[4*i +: 4] = bcd_dig + 4'd1;
            bcd_cy             = 1'b0;
          end
        end else begin
          if (bcd_dig == 4'd0) begin
            bcd_next[4*i +: 4] = 4'd9;
          end else begin
            bcd_next[4*i +: 4] = bcd_dig - 4'd1;
            bcd_cy             = 1'b0;
          end
        end
      end
    end
    bcd_cout = bcd_cy;
  end

  // Next-state logic; clear beats stop, stop beats start.
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (start && !stop) state_d = S_RUN;
        S_RUN:   if (stop)           state_d = S_PAUSE;
        S_PAUSE: if (start && !stop) state_d = S_RUN;
        default:                     state_d = S_IDLE;
      endcase
    end
  end

  // Prescaler, digit update, wrap pulse and running flag.
  always_comb begin
    presc_d   = presc_q;
    digits_d  = digits_q;
    wrap_d    = 1'b0;
    running_d = (state_d == S_RUN);
    if (clear) begin
      presc_d  = 20'd0;
      digits_d = 16'h0000;
    end else if (state_q == S_RUN) begin
      if (tick) begin
        presc_d  = 20'd0;
        digits_d = bcd_next;
        wrap_d   = bcd_cout;
      end else begin
        presc_d = presc_q + 20'd1;
      end
    end
  end

  // Display scan runs in every state; only rst restarts it.
  always_comb begin
    scan_d = scan_q + 16'd1;
    sel_d  = sel_q;
    if (scan_q == SCAN_LAST) begin
      scan_d = 16'd0;
      sel_d  = sel_q + 2'd1;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      presc_q   <= 20'd0;
      digits_q  <= 16'h0000;
      wrap_q    <= 1'b0;
      running_q <= 1'b0;
      scan_q    <= 16'd0;
      sel_q     <= 2'd0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      digits_q  <= digits_d;
      wrap_q    <= wrap_d;
      running_q <= running_d;
      scan_q    <= scan_d;
      sel_q     <= sel_d;
    end
  end

  assign digits  = digits_q;
  assign running = running_q;
  assign wrap    = wrap_q;
  assign an      = ~(4'b0001 << sel_q);
  assign seg_bcd = digits_q[{sel_q, 2'b00} +: 4];

endmodule

// File: tb/tb_bcd4_run_ctrl.sv
// Directed bench for bcd4_run_ctrl with PRESCALE=4, SCAN_DIV=2.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_bcd4_run_ctrl;

  localparam int PRESCALE = 4;
  localparam int SCAN_DIV = 2;

  logic        clk = 1'b0;
  logic        rst, start, stop, clear, up;
  logic [15:0] digits;
  logic        running, wrap;
  logic [3:0]  an, seg_bcd;

  int checks = 0;
  int errors = 0;

  // Reference scan position, kept from the clock and rst only.
  int         m_scan;
  logic [1:0] m_sel;

  bcd4_run_ctrl #(.PRESCALE(PRESCALE), .SCAN_DIV(SCAN_DIV)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .stop    (stop),
    .clear   (clear),
    .up      (up),
    .digits  (digits),
    .running (running),
    .wrap    (wrap),
    .an      (an),
    .seg_bcd (seg_bcd)
  );

  always #5 clk = ~clk;

  // Expected digit select: advances every SCAN_DIV clocks after reset.
  always @(posedge clk) begin
    if (rst) begin
      m_scan <= 0;
      m_sel  <= 2'd0;
    end else if (m_scan == SCAN_DIV - 1) begin
      m_scan <= 0;
      m_sel  <= m_sel + 2'd1;
    end else begin
      m_scan <= m_scan + 1;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
    end
  endtask

  task automatic chk_scan(input string tag, input logic [15:0] exp_digits);
    logic [3:0] exp_an;
    logic [3:0] exp_seg;
    exp_an  = ~(4'b0001 << m_sel);
    exp_seg = exp_digits[{m_sel, 2'b00} +: 4];
    chk({tag, "_an"}, {12'd0, an}, {12'd0, exp_an});
    chk({tag, "_seg"}, {12'd0, seg_bcd}, {12'd0, exp_seg});
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; clear = 1'b0; up = 1'b1;

    // Reset and scan sequence
    cyc(2);
    rst = 1'b0;
    chk("rst_digits",  digits,            16'h0000);
    chk("rst_an",      {12'd0, an},       16'h000e);
    chk("rst_seg",     {12'd0, seg_bcd},  16'h0000);
    chk("rst_running", {15'd0, running},  16'h0000);
    chk("rst_wrap",    {15'd0, wrap},     16'h0000);
    cyc(2); chk("scan_1", {12'd0, an}, 16'h000d);
    cyc(2); chk("scan_2", {12'd0, an}, 16'h000b);
    cyc(2); chk("scan_3", {12'd0, an}, 16'h0007);
    cyc(2); chk("scan_4", {12'd0, an}, 16'h000e);

    // Up count: tick every 4 clocks after RUN entry
    up = 1'b1; start = 1'b1;
    cyc(1);
    start = 1'b0;
    chk("run_entry_running", {15'd0, running}, 16'h0001);
    chk("run_entry_digits",  digits,           16'h0000);
    cyc(3);  chk("first_tick_not_yet", digits, 16'h0000);
    cyc(1);  chk("first_tick",         digits, 16'h0001);
    cyc(35); chk("nine_ticks",         digits, 16'h0009);
    cyc(1);  chk("ten_ticks_carry",    digits, 16'h0010);

    // Pause with prescaler at 2, then resume
    cyc(1);
    chk_scan("scan_run", 16'h0010);
    stop = 1'b1;
    cyc(1);
    stop = 1'b0;
    chk("pause_running", {15'd0, running}, 16'h0000);
    cyc(10);
    chk("pause_frozen",  digits,           16'h0010);
    chk("pause_running2", {15'd0, running}, 16'h0000);
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    chk("resume_running", {15'd0, running}, 16'h0001);
    cyc(1); chk("resume_no_tick", digits, 16'h0010);
    cyc(1); chk("resume_tick",    digits, 16'h0011);

    // start and stop together
    start = 1'b1; stop = 1'b1;
    cyc(1); chk("both_run_to_pause", {15'd0, running}, 16'h0000);
    cyc(1); chk("both_stay_pause",   {15'd0, running}, 16'h0000);
    start = 1'b0; stop = 1'b0;
    chk("both_digits", digits, 16'h0011);

    // Clear from PAUSE
    clear = 1'b1;
    cyc(1);
    clear = 1'b0;
    chk("clear_digits",  digits,           16'h0000);
    chk("clear_running", {15'd0, running}, 16'h0000);

    // Down wrap 0000 -> 9999, then up wrap 9999 -> 0000
    up = 1'b0; start = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(3);
    chk("dn_pre_digits", digits,        16'h0000);
    chk("dn_pre_wrap",   {15'd0, wrap}, 16'h0000);
    cyc(1);
    chk("dn_wrap_digits", digits,        16'h9999);
    chk("dn_wrap_pulse",  {15'd0, wrap}, 16'h0001);
    cyc(1);
    chk("dn_wrap_end", {15'd0, wrap}, 16'h0000);
    up = 1'b1;
    cyc(2);
    chk("up_pre_digits", digits,        16'h9999);
    chk("up_pre_wrap",   {15'd0, wrap}, 16'h0000);
    cyc(1);
    chk("up_wrap_digits", digits,        16'h0000);
    chk("up_wrap_pulse",  {15'd0, wrap}, 16'h0001);
    cyc(1);
    chk("up_wrap_end", {15'd0, wrap}, 16'h0000);

    // Count to 0999 and clear on the tick that would give 1000
    cyc(3998);
    chk("reach_0999", digits, 16'h0999);
    chk_scan("scan_0999", 16'h0999);
    clear = 1'b1;
    cyc(1);
    clear = 1'b0;
    chk("clr_tick_digits",  digits,           16'h0000);
    chk("clr_tick_wrap",    {15'd0, wrap},    16'h0000);
    chk("clr_tick_running", {15'd0, running}, 16'h0000);
    chk_scan("scan_clr_0", 16'h0000);
    cyc(1); chk_scan("scan_clr_1", 16'h0000);
    cyc(1); chk_scan("scan_clr_2", 16'h0000);
    cyc(10);
    chk("idle_holds", digits, 16'h0000);

    // Reset in the middle of a run at 0457
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(1830);
    chk("reach_0457",    digits,           16'h0457);
    chk("run_0457",      {15'd0, running}, 16'h0001);
    chk_scan("scan_0457", 16'h0457);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    chk("mid_rst_digits",  digits,           16'h0000);
    chk("mid_rst_running", {15'd0, running}, 16'h0000);
    chk("mid_rst_wrap",    {15'd0, wrap},    16'h0000);
    chk("mid_rst_an",      {12'd0, an},      16'h000e);
    chk("mid_rst_seg",     {12'd0, seg_bcd}, 16'h0000);
    cyc(20);
    chk("post_rst_idle",    digits,           16'h0000);
    chk("post_rst_running", {15'd0, running}, 16'h0000);
    chk_scan("scan_post_rst", 16'h0000);
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(4);
    chk("post_rst_count", digits, 16'h0001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
